// File: rtl/shim_trig_timestamp_reader.sv
// Drains a FWFT trigger FIFO, pairs 32-bit words into 64-bit timestamps, and
// streams each timestamp with a saturating delta from its predecessor.
module shim_trig_timestamp_reader #(
    parameter int DELTA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    output logic                   data_word_rd_en,
    input  logic [31:0]            data_word,
    input  logic                   data_buf_empty,
    output logic [63:0]            ts_tdata,
    output logic [DELTA_WIDTH-1:0] ts_delta,
    output logic                   ts_first,
    output logic                   ts_tvalid,
    input  logic                   ts_tready,
    output logic [31:0]            trig_count,
    output logic                   order_err
);

    typedef enum logic {
        S_LOW,
        S_HIGH
    } state_t;

    localparam logic [63:0] SAT_MAX =
        (DELTA_WIDTH >= 64) ? '1 : ((64'd1 << DELTA_WIDTH) - 64'd1);

    state_t                 state_q, state_d;
    logic [31:0]            low_hold_q, low_hold_d;
    logic [63:0]            prev_ts_q, prev_ts_d;
    logic                   first_q, first_d;
    logic [63:0]            ts_tdata_q, ts_tdata_d;
    logic [DELTA_WIDTH-1:0] ts_delta_q, ts_delta_d;
    logic                   ts_first_q, ts_first_d;
    logic                   ts_tvalid_q, ts_tvalid_d;
    logic [31:0]            trig_count_q, trig_count_d;
    logic                   order_err_q, order_err_d;

    logic        pop;
    logic        handshake;
    logic        slot_free;
    logic [63:0] ts_full;
    logic [63:0] ts_diff;

    assign handshake = ts_tvalid_q && ts_tready;
    assign slot_free = !ts_tvalid_q || ts_tready;
    assign ts_full   = {data_word, low_hold_q};
    assign ts_diff   = ts_full - prev_ts_q;

    // The pop strobe must never fire while empty, in reset, or during flush.
    always_comb begin
        pop = 1'b0;
        if (!rst && !flush && !data_buf_empty) begin
            case (state_q)
                S_LOW:   pop = 1'b1;
                S_HIGH:  pop = slot_free;
                default: pop = 1'b0;
            endcase
        end
    end

    assign data_word_rd_en = pop;

    // NOTE: every _d starts as its _q so no path through this block leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        low_hold_d   = low_hold_q;
        prev_ts_d    = prev_ts_q;
        first_d      = first_q;
        ts_tdata_d   = ts_tdata_q;
        ts_delta_d   = ts_delta_q;
        ts_first_d   = ts_first_q;
        ts_tvalid_d  = ts_tvalid_q;
        trig_count_d = trig_count_q;
        order_err_d  = order_err_q;

        if (handshake) begin
            ts_tvalid_d  = 1'b0;
            trig_count_d = trig_count_q + 32'd1;
        end

        if (pop && state_q == S_LOW) begin
            low_hold_d = data_word;
            state_d    = S_HIGH;
        end

        if (pop && state_q == S_HIGH) begin
            ts_tdata_d  = ts_full;
            ts_tvalid_d = 1'b1;
            prev_ts_d   = ts_full;
            first_d     = 1'b0;
            state_d     = S_LOW;
            if (first_q) begin
                ts_delta_d = '0;
                ts_first_d = 1'b1;
            end else if (ts_full >= prev_ts_q) begin
                ts_delta_d = (ts_diff > SAT_MAX) ? '1 : ts_diff[DELTA_WIDTH-1:0];
                ts_first_d = 1'b0;
            end else begin
                ts_delta_d  = '0;
                ts_first_d  = 1'b0;
                order_err_d = 1'b1;
            end
        end

        // Flush wins over any same-cycle handshake; that handshake is not counted.
        if (flush) begin
            state_d      = S_LOW;
            low_hold_d   = '0;
            prev_ts_d    = '0;
            first_d      = 1'b1;
            ts_tvalid_d  = 1'b0;
            trig_count_d = trig_count_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOW;
            low_hold_q   <= '0;
            prev_ts_q    <= '0;
            first_q      <= 1'b1;
            ts_tdata_q   <= '0;
            ts_delta_q   <= '0;
            ts_first_q   <= 1'b0;
            ts_tvalid_q  <= 1'b0;
            trig_count_q <= '0;
            order_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            low_hold_q   <= low_hold_d;
            prev_ts_q    <= prev_ts_d;
            first_q      <= first_d;
            ts_tdata_q   <= ts_tdata_d;
            ts_delta_q   <= ts_delta_d;
            ts_first_q   <= ts_first_d;
            ts_tvalid_q  <= ts_tvalid_d;
            trig_count_q <= trig_count_d;
            order_err_q  <= order_err_d;
        end
    end

    assign ts_tdata   = ts_tdata_q;
    assign ts_delta   = ts_delta_q;
    assign ts_first   = ts_first_q;
    assign ts_tvalid  = ts_tvalid_q;
    assign trig_count = trig_count_q;
    assign order_err  = order_err_q;

endmodule

// File: tb/tb_shim_trig_timestamp_reader.sv
// Directed bench for shim_trig_timestamp_reader: FWFT FIFO model feeding the
// DUT, expected timestamps queued at push time and compared on each handshake.
module tb_shim_trig_timestamp_reader;

    typedef struct packed {
        logic [63:0] ts;
        logic [31:0] delta;
        logic        first;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        data_word_rd_en;
    logic [31:0] data_word;
    logic        data_buf_empty;
    logic [63:0] ts_tdata;
    logic [31:0] ts_delta;
    logic        ts_first;
    logic        ts_tvalid;
    logic        ts_tready;
    logic [31:0] trig_count;
    logic        order_err;

    logic [31:0] fifo_q[$];
    exp_t        exp_q[$];
    int          hs_times[$];
    int          tests;
    int          fails;
    int          pops;
    int          hs_count;
    int          cyc;
    logic [63:0] m_prev;
    logic        m_first;
    logic [63:0] last_ts;
    logic [31:0] last_delta;
    logic        last_first;

    shim_trig_timestamp_reader #(.DELTA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .data_word_rd_en(data_word_rd_en),
        .data_word      (data_word),
        .data_buf_empty (data_buf_empty),
        .ts_tdata       (ts_tdata),
        .ts_delta       (ts_delta),
        .ts_first       (ts_first),
        .ts_tvalid      (ts_tvalid),
        .ts_tready      (ts_tready),
        .trig_count     (trig_count),
        .order_err      (order_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        data_buf_empty = (fifo_q.size() == 0);
        data_word      = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    task automatic model_clear();
        m_first = 1'b1;
        m_prev  = 64'h0;
    endtask

    // Pushes both words and queues the timestamp the DUT should report for them.
    task automatic push_pair(input logic [63:0] ts);
        exp_t        e;
        logic [63:0] d;
        push_word(ts[31:0]);
        push_word(ts[63:32]);
        e.ts = ts;
        if (m_first) begin
            e.delta = 32'h0;
            e.first = 1'b1;
        end else if (ts >= m_prev) begin
            d       = ts - m_prev;
            e.delta = (d > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
            e.first = 1'b0;
        end else begin
            e.delta = 32'h0;
            e.first = 1'b0;
        end
        exp_q.push_back(e);
        m_prev  = ts;
        m_first = 1'b0;
    endtask

    // One clock: sample at the falling edge, retire the FIFO pop at the rising edge.
    task automatic tick();
        logic        do_pop;
        exp_t        e;
        logic [31:0] dummy;
        @(negedge clk);
        do_pop = data_word_rd_en && !data_buf_empty;
        if (do_pop) pops++;
        if ((rst || flush) && ts_tvalid) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end else if (ts_tvalid && ts_tready) begin
            hs_count++;
            hs_times.push_back(cyc);
            last_ts    = ts_tdata;
            last_delta = ts_delta;
            last_first = ts_first;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb_ts", ts_tdata, e.ts);
                check("sb_delta", 64'(ts_delta), 64'(e.delta));
                check("sb_first", 64'(ts_first), 64'(e.first));
            end
        end
        @(posedge clk);
        if (do_pop) dummy = fifo_q.pop_front();
        cyc++;
        #1 refresh();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || ts_tvalid) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(n < budget), 64'(1));
    endtask

    function automatic int last_gap();
        int s;
        s = hs_times.size();
        return (s < 2) ? -1 : hs_times[s-1] - hs_times[s-2];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(data_word_rd_en), 64'(0));
        check({tag, "_tdata"}, ts_tdata, 64'(0));
        check({tag, "_delta"}, 64'(ts_delta), 64'(0));
        check({tag, "_first"}, 64'(ts_first), 64'(0));
        check({tag, "_tvalid"}, 64'(ts_tvalid), 64'(0));
        check({tag, "_count"}, 64'(trig_count), 64'(0));
        check({tag, "_order_err"}, 64'(order_err), 64'(0));
    endtask

    initial begin
        int p0;
        int c0;
        int n;
        tests = 0; fails = 0; pops = 0; hs_count = 0; cyc = 0;
        rst = 1'b1; flush = 1'b0; ts_tready = 1'b0;
        model_clear();
        refresh();

        // Reset state, and no pop while reset holds even with data waiting.
        tick(); tick();
        check_reset_outputs("reset");
        ts_tready = 1'b1;
        push_pair(64'h10);
        push_pair(64'h110);
        #1;
        check("rd_en_in_reset", 64'(data_word_rd_en), 64'(0));
        tick();
        check("no_pop_in_reset", 64'(pops), 64'(0));

        // Basic pairing and throughput.
        rst = 1'b0;
        drain("basic_drain", 40);
        check("basic_pops", 64'(pops), 64'(4));
        check("basic_count", 64'(trig_count), 64'(2));
        check("basic_last_ts", last_ts, 64'h110);
        check("basic_last_delta", 64'(last_delta), 64'h100);
        check("basic_gap", 64'(last_gap()), 64'(2));

        // Carry across the word boundary, then saturation.
        push_pair(64'h0000_0000_FFFF_FFF0);
        push_pair(64'h0000_0001_0000_0010);
        drain("carry_drain", 40);
        check("carry_delta", 64'(last_delta), 64'h20);
        push_pair(64'h0000_0003_0000_0000);
        drain("sat_drain", 40);
        check("sat_delta", 64'(last_delta), 64'hFFFF_FFFF);
        check("sat_order_err", 64'(order_err), 64'(0));

        // Ordering error is sticky.
        push_pair(64'h500);
        push_pair(64'h400);
        drain("order_drain", 40);
        check("order_delta_zero", 64'(last_delta), 64'(0));
        check("order_err_set", 64'(order_err), 64'(1));
        push_pair(64'h600);
        drain("order_drain2", 40);
        check("order_after_delta", 64'(last_delta), 64'h200);
        check("order_err_sticky", 64'(order_err), 64'(1));

        // Backpressure: first output held, exactly one pending low word.
        ts_tready = 1'b0;
        p0 = pops;
        push_pair(64'h1000);
        push_pair(64'h1100);
        push_pair(64'h1300);
        repeat (4) tick();
        check("bp_valid_early", 64'(ts_tvalid), 64'(1));
        check("bp_ts_early", ts_tdata, 64'h1000);
        check("bp_delta", 64'(ts_delta), 64'hA00);
        repeat (8) tick();
        check("bp_ts_late", ts_tdata, 64'h1000);
        check("bp_valid_late", 64'(ts_tvalid), 64'(1));
        check("bp_pops", 64'(pops - p0), 64'(3));
        check("bp_rd_en_low", 64'(data_word_rd_en), 64'(0));
        c0 = hs_count;
        ts_tready = 1'b1;
        drain("bp_drain", 40);
        check("bp_outputs", 64'(hs_count - c0), 64'(3));
        check("bp_gap", 64'(last_gap()), 64'(2));
        check("bp_count", 64'(trig_count), 64'(hs_count));

        // Flush after an orphan word resynchronises pairing.
        p0 = pops;
        push_word(32'hDEAD);
        tick(); tick();
        check("orphan_popped", 64'(pops - p0), 64'(1));
        check("orphan_waiting", 64'(data_word_rd_en), 64'(0));
        flush = 1'b1;
        model_clear();
        push_pair(64'h900);
        #1;
        check("flush_no_pop", 64'(data_word_rd_en), 64'(0));
        tick();
        flush = 1'b0;
        drain("flush_drain", 40);
        check("flush_ts", last_ts, 64'h900);
        check("flush_first", 64'(last_first), 64'(1));
        check("flush_delta", 64'(last_delta), 64'(0));

        // Flush coincident with a handshake drops the output uncounted.
        ts_tready = 1'b0;
        push_pair(64'hA00);
        n = 0;
        while (!ts_tvalid && n < 10) begin
            tick();
            n++;
        end
        check("fhs_valid", 64'(ts_tvalid), 64'(1));
        ts_tready = 1'b1;
        flush = 1'b1;
        model_clear();
        tick();
        flush = 1'b0;
        check("fhs_count", 64'(trig_count), 64'(12));
        check("fhs_tvalid", 64'(ts_tvalid), 64'(0));
        check("fhs_order_err", 64'(order_err), 64'(1));

        // Reset in S_HIGH with an output pending.
        ts_tready = 1'b0;
        p0 = pops;
        push_pair(64'hB00);
        push_pair(64'hC00);
        n = 0;
        while ((pops - p0) < 3 && n < 20) begin
            tick();
            n++;
        end
        check("rst_mid_pops", 64'(pops - p0), 64'(3));
        check("rst_mid_valid", 64'(ts_tvalid), 64'(1));
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        refresh();
        model_clear();
        tick();
        check_reset_outputs("rst_mid");
        hs_count = 0;
        rst = 1'b0;
        ts_tready = 1'b1;
        push_pair(64'hD00);
        drain("rst_drain", 40);
        check("rst_after_ts", last_ts, 64'hD00);
        check("rst_after_first", 64'(last_first), 64'(1));
        check("rst_after_count", 64'(trig_count), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
